// File: rtl/sccb_reg_writer_if.sv
// Request handshake and SCCB pin bundle for sccb_reg_writer.
// slave = the writer itself; master = config sequencer plus sensor side.
interface sccb_reg_writer_if;
  logic       WR_VALID;
  logic       WR_READY;
  logic [7:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       DONE;
  logic       ACK_ERR;
  logic       SIO_C;
  logic       SIO_D;
  logic       SIO_D_OE;
  logic       SIO_D_IN;

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA, SIO_D_IN,
    output WR_READY, DONE, ACK_ERR, SIO_C, SIO_D, SIO_D_OE
  );

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA, SIO_D_IN,
    input  WR_READY, DONE, ACK_ERR, SIO_C, SIO_D, SIO_D_OE
  );
endinterface

// File: rtl/sccb_reg_writer.sv
// SCCB master serialising 3-phase register writes (device ID, sub-address, data).
// Define SCCB_RESET_WAIT_EN to add a hold-off after a COM7 soft-reset write.
module sccb_reg_writer #(
  parameter int unsigned QTR_CYCLES = 63,
  parameter logic [7:0]  DEVICE_ID  = 8'h42
`ifdef SCCB_RESET_WAIT_EN
  , parameter int unsigned RESET_WAIT_CYCLES = 25000
`endif
) (
  input  logic             CLK,
  input  logic             RESET_N,
  sccb_reg_writer_if.slave bus
);
  localparam int unsigned QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_BITS  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef SCCB_RESET_WAIT_EN
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam int unsigned WW = $clog2(RESET_WAIT_CYCLES + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
`endif

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          nack_q, nack_d;
  logic          ready_q, ready_d, done_q, done_d, ackerr_q, ackerr_d;
  logic          sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
  logic          qtick;
  logic [7:0]    cur_byte;

  assign qtick = (qcnt_q == QW'(QTR_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    data_d   = data_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    ackerr_d = ackerr_q;
`ifdef SCCB_RESET_WAIT_EN
    wcnt_d   = wcnt_q;
`endif
    if (state_q == ST_START || state_q == ST_BITS || state_q == ST_STOP)
      qcnt_d = qtick ? '0 : qcnt_q + QW'(1);

    case (state_q)
      ST_IDLE: begin
        qcnt_d = '0;
        if (bus.WR_VALID && ready_q) begin
          state_d  = ST_START;
          qtr_d    = '0;
          addr_d   = bus.WR_ADDR;
          data_d   = bus.WR_DATA;
          nack_d   = 1'b0;
          ackerr_d = 1'b0;
        end
      end
      ST_START: if (qtick) begin
        if (qtr_q == 2'd1) begin
          state_d = ST_BITS;
          qtr_d   = '0;
          bit_d   = '0;
          phase_d = '0;
        end else begin
          qtr_d = qtr_q + 2'd1;
        end
      end
      ST_BITS: begin
        // ACK sampled on the last cycle of Q2, while SIO_C is high
        if (qtick && qtr_q == 2'd2 && bit_q == 4'd8 && bus.SIO_D_IN)
          nack_d = 1'b1;
        if (qtick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d = '0;
              if (phase_q == 2'd2) state_d = ST_STOP;
              else                 phase_d = phase_q + 2'd1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      ST_STOP: if (qtick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
`ifdef SCCB_RESET_WAIT_EN
          if (addr_q == 8'h12 && data_q[7]) begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
          end else begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            ackerr_d = nack_q;
          end
`else
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          ackerr_d = nack_q;
`endif
        end
      end
`ifdef SCCB_RESET_WAIT_EN
      ST_WAIT: begin
        wcnt_d = wcnt_q + WW'(1);
        if (wcnt_q == WW'(RESET_WAIT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          ackerr_d = nack_q;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next-state so the pins are registered yet aligned to the state
    cur_byte = (phase_d == 2'd0) ? DEVICE_ID : (phase_d == 2'd1) ? addr_d : data_d;
    ready_d  = (state_d == ST_IDLE);
    sioc_d   = 1'b1;
    siod_d   = 1'b1;
    oe_d     = 1'b1;
    case (state_d)
      ST_START: begin
        sioc_d = (qtr_d == 2'd0);
        siod_d = 1'b0;
      end
      ST_BITS: begin
        sioc_d = qtr_d[1];
        siod_d = siod_q;
        oe_d   = oe_q;
        if (qtr_d == 2'd1) begin
          oe_d   = (bit_d != 4'd8);
          siod_d = (bit_d == 4'd8) ? 1'b1 : cur_byte[3'(4'd7 - bit_d)];
        end
      end
      ST_STOP: begin
        sioc_d = (qtr_d != 2'd0);
        siod_d = qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      qcnt_q   <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      nack_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
      sioc_q   <= 1'b1;
      siod_q   <= 1'b1;
      oe_q     <= 1'b1;
`ifdef SCCB_RESET_WAIT_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      nack_q   <= nack_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ackerr_q <= ackerr_d;
      sioc_q   <= sioc_d;
      siod_q   <= siod_d;
      oe_q     <= oe_d;
`ifdef SCCB_RESET_WAIT_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  assign bus.WR_READY = ready_q;
  assign bus.DONE     = done_q;
  assign bus.ACK_ERR  = ackerr_q;
  assign bus.SIO_C    = sioc_q;
  assign bus.SIO_D    = siod_q;
  assign bus.SIO_D_OE = oe_q;
endmodule

// File: tb/tb_sccb_reg_writer.sv
// Scoreboard bench for sccb_reg_writer: driver pushes expected transactions,
// a monitor decodes the SCCB pins and checks each one at DONE.
module tb_sccb_reg_writer;
  localparam int unsigned Q   = 4;
  localparam int unsigned LAT = 114 * Q;
`ifdef SCCB_RESET_WAIT_EN
  localparam int unsigned RWC = 100;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sccb_reg_writer_if bus ();

  sccb_reg_writer #(
    .QTR_CYCLES(Q),
    .DEVICE_ID (8'h42)
`ifdef SCCB_RESET_WAIT_EN
    , .RESET_WAIT_CYCLES(RWC)
`endif
  ) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [2:0]  nk;
    int unsigned done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic [2:0]  cur_nack = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned model_lat(input logic [7:0] a, input logic [7:0] d);
    int unsigned l;
    l = LAT;
`ifdef SCCB_RESET_WAIT_EN
    if (a == 8'h12 && d[7]) l += RWC;
`else
    if (a == d && a != a) l = 0;
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Sensor: after the 9th/18th/27th SIO_C rise, drive the chosen ACK/NACK; noise otherwise
  initial begin : sensor
    int unsigned rises;
    logic        pc;
    rises = 0;
    pc    = 1'b1;
    bus.SIO_D_IN = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.WR_READY) begin
        rises = 0;
      end else if (!pc && bus.SIO_C) begin
        rises++;
        if (rises % 9 == 0 && rises <= 27) bus.SIO_D_IN = cur_nack[rises / 9 - 1];
        else                               bus.SIO_D_IN = 1'($urandom_range(0, 1));
      end
      pc = bus.SIO_C;
    end
  end

  initial begin : monitor
    logic [1:0]  caps[$];
    logic        pc, pd;
    int unsigned idle_run;
    bit          after_stop;
    exp_t        e;
    logic [26:0] gd, go, wd, wo;
    pc = 1'b1; pd = 1'b1; idle_run = 0; after_stop = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        caps.delete();
        pc = 1'b1; pd = 1'b1; idle_run = 0; after_stop = 1'b0;
        continue;
      end
      if (pc && pd && bus.SIO_C && !bus.SIO_D && after_stop) begin
        chk("bus_free_before_start", 32'(idle_run >= Q), 32'd1);
        after_stop = 1'b0;
      end
      idle_run = (bus.SIO_C && bus.SIO_D) ? idle_run + 1 : 0;
      if (!pc && bus.SIO_C) caps.push_back({bus.SIO_D, bus.SIO_D_OE});
      if (bus.DONE) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got DONE at cycle %0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("ack_err", 32'(bus.ACK_ERR), 32'(|e.nk));
          chk("ready_at_done", 32'(bus.WR_READY), 32'd1);
          chk("sioc_rise_count", 32'(caps.size()), 32'd28);
          gd = '0; go = '0;
          for (int s = 0; s < 27 && s < caps.size(); s++) begin
            gd[26-s] = caps[s][1];
            go[26-s] = caps[s][0];
          end
          wd = {8'h42, 1'b1, e.a, 1'b1, e.d, 1'b1};
          wo = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
          chk("serial_data", 32'(gd), 32'(wd));
          chk("serial_oe", 32'(go), 32'(wo));
        end
        caps.delete();
        after_stop = 1'b1;
      end
      pc = bus.SIO_C;
      pd = bus.SIO_D;
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] d, input logic [2:0] nk,
                       input bit keep, input bit pulses);
    int unsigned w;
    exp_t        e;
    w = 0;
    bus.WR_VALID = 1'b1;
    bus.WR_ADDR  = a;
    bus.WR_DATA  = d;
    while (!bus.WR_READY && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.WR_READY) begin
      total++; bad++;
      $display("FAIL accept_timeout: got WR_READY=0 want 1 within 3000 cycles");
      bus.WR_VALID = 1'b0;
      return;
    end
    cur_nack   = nk;
    e.a        = a;
    e.d        = d;
    e.nk       = nk;
    e.done_cyc = cyc + 1 + model_lat(a, d);
    exp_q.push_back(e);
    @(negedge clk);
    chk("ready_low_after_accept", 32'(bus.WR_READY), 32'd0);
    chk("ack_err_clear_after_accept", 32'(bus.ACK_ERR), 32'd0);
    chk("start_s0_cd", 32'({bus.SIO_C, bus.SIO_D}), 32'd2);
    if (!keep) bus.WR_VALID = 1'b0;
    if (pulses) begin
      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = 8'($urandom);
        bus.WR_DATA  = 8'($urandom);
        @(negedge clk);
        bus.WR_VALID = 1'b0;
        repeat (40) @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] ra, rd;
    logic [2:0] rn;
    bit         rk;
    bus.WR_VALID = 1'b0;
    bus.WR_ADDR  = '0;
    bus.WR_DATA  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.WR_READY), 32'd1);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_ack_err", 32'(bus.ACK_ERR), 32'd0);
    chk("rst_sioc", 32'(bus.SIO_C), 32'd1);
    chk("rst_siod", 32'(bus.SIO_D), 32'd1);
    chk("rst_oe", 32'(bus.SIO_D_OE), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(8'h12, 8'h80, 3'b000, 1'b0, 1'b0);
    drain();
    issue(8'h12, 8'h80, 3'b010, 1'b0, 1'b0);
    drain();
    chk("ack_err_held_after_done", 32'(bus.ACK_ERR), 32'd1);

    issue(8'h11, 8'h01, 3'b000, 1'b1, 1'b0);
    issue(8'h3A, 8'h04, 3'b100, 1'b0, 1'b0);
    drain();

    issue(8'h55, 8'hAA, 3'b001, 1'b0, 1'b1);
    drain();

    issue(8'h5C, 8'($urandom), 3'b000, 1'b0, 1'b0);
    repeat (52 * Q + 1) @(negedge clk);
    chk("slot12_q2_sioc_high", 32'(bus.SIO_C), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_sioc", 32'(bus.SIO_C), 32'd1);
    chk("async_rst_siod", 32'(bus.SIO_D), 32'd1);
    chk("async_rst_oe", 32'(bus.SIO_D_OE), 32'd1);
    chk("async_rst_ready", 32'(bus.WR_READY), 32'd1);
    chk("async_rst_done", 32'(bus.DONE), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(8'h0C, 8'h3F, 3'b000, 1'b0, 1'b0);
    drain();

    issue(8'h12, 8'h00, 3'b000, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      rn = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      rk = (i != 7) && ($urandom_range(0, 2) == 0);
      issue(ra, rd, rn, rk, 1'b0);
      if (!rk) begin
        drain();
        repeat ($urandom_range(0, 10)) @(negedge clk);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
